// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   // IF/ID payload: instruction plus the address of the next sequential fetch
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc1;
   } if_id_t;

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
      return PC_W'(pc + PC_W'(1));
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid register holding an instruction that returned while decode was stalled.
module if_skid_buf
   import if_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_clear,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [PC_W-1:0]    i_pc1,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_pc1,
   output logic               o_valid
);

   if_id_t r_entry;
   logic   r_valid;

   // Clear wins over load; the fetch FSM never asserts both together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entry <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_entry <= '{instr: i_instr, pc1: i_pc1};
         r_valid <= 1'b1;
      end
   end

   assign o_instr = r_entry.instr;
   assign o_pc1   = r_entry.pc1;
   assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, imem req/ack handshake, stall skid and
// redirect squashing; writes the IF/ID register inputs.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               imem_req_o,
   output logic [PC_W-1:0]    imem_addr_o,
   input  logic               imem_ack_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic [PC_W-1:0]    pc_plus1_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic               instr_valid_o
);

   fetch_state_t       r_state;
   logic [PC_W-1:0]    r_fetch_pc;
   logic [PC_W-1:0]    r_target;
   logic [PC_W-1:0]    r_pc_plus1;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;

   fetch_state_t       w_state_nxt;
   logic [PC_W-1:0]    w_pc_nxt;
   logic [PC_W-1:0]    w_target_nxt;
   logic [PC_W-1:0]    w_pc1_nxt;
   logic [INSTR_W-1:0] w_instr_nxt;
   logic               w_valid_nxt;
   logic               w_skid_load;
   logic               w_skid_clear;
   logic [PC_W-1:0]    w_pc_inc;
   logic [INSTR_W-1:0] w_skid_instr;
   logic [PC_W-1:0]    w_skid_pc1;
   logic               w_skid_valid;

   assign w_pc_inc = pc_inc(r_fetch_pc);

   if_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_instr (imem_rdata_i),
      .i_pc1   (w_pc_inc),
      .o_instr (w_skid_instr),
      .o_pc1   (w_skid_pc1),
      .o_valid (w_skid_valid)
   );

   // State, PC and IF/ID output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= FETCH;
         r_fetch_pc <= RESET_PC;
         r_target   <= RESET_PC;
         r_pc_plus1 <= '0;
         r_instr    <= NOP_INSTR;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_pc_nxt;
         r_target   <= w_target_nxt;
         r_pc_plus1 <= w_pc1_nxt;
         r_instr    <= w_instr_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   // Next-state, PC and output selection; redirect outranks stall and fetch
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_fetch_pc;
      w_target_nxt = r_target;
      w_pc1_nxt    = r_pc_plus1;
      w_instr_nxt  = r_instr;
      w_valid_nxt  = r_valid;
      w_skid_load  = 1'b0;
      w_skid_clear = 1'b0;

      case (r_state)
         FETCH: begin
            if (redirect_i) begin
               w_instr_nxt = NOP_INSTR;
               w_valid_nxt = 1'b0;
               if (imem_ack_i) begin
                  w_pc_nxt = redirect_pc_i;
               end else begin
                  w_target_nxt = redirect_pc_i;
                  w_state_nxt  = DROP;
               end
            end else if (imem_ack_i) begin
               w_pc_nxt = w_pc_inc;
               if (stall_i) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = HOLD;
               end else begin
                  w_instr_nxt = imem_rdata_i;
                  w_pc1_nxt   = w_pc_inc;
                  w_valid_nxt = 1'b1;
               end
            end else if (!stall_i) begin
               w_instr_nxt = NOP_INSTR;
               w_valid_nxt = 1'b0;
            end
         end

         HOLD: begin
            if (redirect_i) begin
               w_instr_nxt  = NOP_INSTR;
               w_valid_nxt  = 1'b0;
               w_pc_nxt     = redirect_pc_i;
               w_skid_clear = 1'b1;
               w_state_nxt  = FETCH;
            end else if (!stall_i) begin
               w_instr_nxt  = w_skid_instr;
               w_pc1_nxt    = w_skid_pc1;
               w_valid_nxt  = w_skid_valid;
               w_skid_clear = 1'b1;
               w_state_nxt  = FETCH;
            end
         end

         DROP: begin
            // Squashed request stays on the bus until acked; its data is discarded
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
            if (imem_ack_i) begin
               w_pc_nxt    = redirect_i ? redirect_pc_i : r_target;
               w_state_nxt = FETCH;
            end else if (redirect_i) begin
               w_target_nxt = redirect_pc_i;
            end
         end

         default: begin
            w_state_nxt = FETCH;
         end
      endcase
   end

   assign imem_req_o    = !rst && (r_state != HOLD);
   assign imem_addr_o   = r_fetch_pc;
   assign pc_plus1_o    = r_pc_plus1;
   assign instr_o       = r_instr;
   assign instr_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-configurable memory model, in-order scoreboard
// of expected (instr, pc+1) pairs, and directed cycle checks.
module tb_if_fetch_unit;
   import if_pkg::*;

   logic               clk;
   logic               rst;
   logic               stall_i;
   logic               redirect_i;
   logic [PC_W-1:0]    redirect_pc_i;
   logic               imem_req_o;
   logic [PC_W-1:0]    imem_addr_o;
   logic               imem_ack_i;
   logic [INSTR_W-1:0] imem_rdata_i;
   logic [PC_W-1:0]    pc_plus1_o;
   logic [INSTR_W-1:0] instr_o;
   logic               instr_valid_o;

   int n_checks = 0;
   int n_errors = 0;

   bit mem_en  = 1'b0;
   int mem_lat = 0;
   int mem_cnt;

   logic [31:0] sb_instr[$];
   logic [7:0]  sb_pc1[$];
   logic [31:0] exp_instr;
   logic [7:0]  exp_pc1;

   logic            edge_stall = 1'b0;
   logic            pend       = 1'b0;
   logic [PC_W-1:0] pend_addr  = '0;

   if_fetch_unit #(.RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .pc_plus1_o    (pc_plus1_o),
      .instr_o       (instr_o),
      .instr_valid_o (instr_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] addr);
      sb_instr.push_back(32'(addr) << 2);
      sb_pc1.push_back(8'(addr + 8'd1));
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Memory: returns addr*4 after mem_lat wait cycles
   always_comb begin
      imem_ack_i   = !rst && mem_en && imem_req_o && (mem_cnt == mem_lat);
      imem_rdata_i = imem_ack_i ? (32'(imem_addr_o) << 2) : 32'hDEAD_BEEF;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) mem_cnt <= 0;
      else if (mem_en && imem_req_o && !imem_ack_i) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
   end

   always @(posedge clk) edge_stall <= stall_i;

   // Scoreboard: each new valid output must match the next expected fetch
   always @(negedge clk) begin
      if (!rst && instr_valid_o && !edge_stall) begin
         if (sb_instr.size() == 0) begin
            check("sb_extra_instr", 32'(instr_valid_o), 32'd0);
         end else begin
            exp_instr = sb_instr.pop_front();
            exp_pc1   = sb_pc1.pop_front();
            check("sb_instr", instr_o, exp_instr);
            check("sb_pc1", 32'(pc_plus1_o), 32'(exp_pc1));
         end
      end
   end

   // Handshake: an unacked request keeps its address and is never withdrawn
   always @(negedge clk) begin
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check("req_held", 32'(imem_req_o), 32'd1);
            check("addr_stable", 32'(imem_addr_o), 32'(pend_addr));
         end
         pend      = imem_req_o && !imem_ack_i;
         pend_addr = imem_addr_o;
      end
   end

   task automatic chk_out(input string tag, input logic [31:0] ins, input logic [7:0] pc1,
                          input logic vld);
      check({tag, "_instr"}, instr_o, ins);
      check({tag, "_pc1"}, 32'(pc_plus1_o), 32'(pc1));
      check({tag, "_valid"}, 32'(instr_valid_o), 32'(vld));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      step(); step();
      chk_out("reset", 32'h0, 8'h00, 1'b0);
      check("reset_req", 32'(imem_req_o), 32'd0);
      check("reset_addr", 32'(imem_addr_o), 32'h00);

      // Zero-wait streaming
      rst = 1'b0; mem_en = 1'b1; mem_lat = 0;
      push_exp(8'h00); push_exp(8'h01); push_exp(8'h02);
      #1 check("first_req", 32'(imem_req_o), 32'd1);
      step(); chk_out("zw0", 32'd0, 8'd1, 1'b1);
      step(); chk_out("zw1", 32'd4, 8'd2, 1'b1);
      step(); chk_out("zw2", 32'd8, 8'd3, 1'b1);

      // Three-cycle stall with ack on the first
      stall_i = 1'b1; push_exp(8'h03);
      step(); chk_out("stall0", 32'd8, 8'd3, 1'b1);
      check("hold_req0", 32'(imem_req_o), 32'd0);
      step(); chk_out("stall1", 32'd8, 8'd3, 1'b1);
      step(); chk_out("stall2", 32'd8, 8'd3, 1'b1);
      stall_i = 1'b0; mem_en = 1'b0;
      step(); chk_out("skid_out", 32'd12, 8'd4, 1'b1);
      step(); chk_out("bubble_nomem", 32'd0, 8'd4, 1'b0);

      // Two-cycle latency
      mem_en = 1'b1; mem_lat = 2; push_exp(8'h04);
      #1 check("lat_addr0", 32'(imem_addr_o), 32'h04);
      step(); check("lat_bub0", 32'(instr_valid_o), 32'd0);
      check("lat_addr1", 32'(imem_addr_o), 32'h04);
      step(); check("lat_bub1", 32'(instr_valid_o), 32'd0);
      check("lat_addr2", 32'(imem_addr_o), 32'h04);
      step(); chk_out("lat_val", 32'd16, 8'd5, 1'b1);

      // Redirect while request to 0x05 is outstanding
      redirect_i = 1'b1; redirect_pc_i = 8'h40;
      #1 check("redir_addr_old", 32'(imem_addr_o), 32'h05);
      step(); redirect_i = 1'b0;
      check("drop_bub0", 32'(instr_valid_o), 32'd0);
      #1 check("drop_addr", 32'(imem_addr_o), 32'h05);
      check("drop_req", 32'(imem_req_o), 32'd1);
      step();
      step(); check("drop_bub1", 32'(instr_valid_o), 32'd0);
      mem_lat = 0; push_exp(8'h40);
      #1 check("target_addr", 32'(imem_addr_o), 32'h40);
      step(); chk_out("target_out", 32'h100, 8'h41, 1'b1);
      push_exp(8'h41);
      step(); chk_out("pre_stall", 32'h104, 8'h42, 1'b1);

      // Redirect together with stall: bubble despite stall, skid discarded
      stall_i = 1'b1;
      step(); chk_out("frozen", 32'h104, 8'h42, 1'b1);
      redirect_i = 1'b1; redirect_pc_i = 8'hFF;
      step(); check("rs_bubble_valid", 32'(instr_valid_o), 32'd0);
      check("rs_bubble_instr", instr_o, 32'h0);
      redirect_i = 1'b0; stall_i = 1'b0; push_exp(8'hFF);
      #1 check("rs_addr", 32'(imem_addr_o), 32'hFF);

      // PC wrap
      step(); chk_out("wrap_out", 32'h3FC, 8'h00, 1'b1);
      #1 check("wrap_addr", 32'(imem_addr_o), 32'h00);
      push_exp(8'h00);
      step(); chk_out("post_wrap", 32'h0, 8'h01, 1'b1);
      mem_en = 1'b0; mem_lat = 2;
      step(); chk_out("idle", 32'h0, 8'h01, 1'b0);

      // Asynchronous reset mid-transaction
      #1 rst = 1'b1;
      #1 chk_out("areset", 32'h0, 8'h00, 1'b0);
      check("areset_req", 32'(imem_req_o), 32'd0);
      check("areset_addr", 32'(imem_addr_o), 32'h00);
      step(); step();
      rst = 1'b0;
      repeat (3) step();
      check("post_reset_valid", 32'(instr_valid_o), 32'd0);
      check("sb_drained", 32'(sb_instr.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage: owns the program counter, issues requests to instruction memory over a req/ack handshake, and drives the fetched instruction plus incremented PC into IF_ID_Register. Handles decode-stage stalls with a one-entry skid buffer and branch/jump redirects with in-flight request squashing. It is the writer side of the IF/ID interface. IF_ID_Register recovers the fetch address as pc_plus1_o − 1.

## Interface
- PC_W, 8, PC / instruction-address width
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, first fetch address after reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- stall_i  in  1  hazard unit: hold IF/ID outputs this cycle
- redirect_i  in  1  branch/jump taken; flush and refetch
- redirect_pc_i  in  PC_W  redirect target address
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  PC_W  request address
- imem_ack_i  in  1  memory response valid; data on imem_rdata_i same cycle
- imem_rdata_i  in  INSTR_W  fetched instruction
- pc_plus1_o  out  PC_W  fetch address + 1 (to IF_ID_Register inPC)
- instr_o  out  INSTR_W  instruction (to IF_ID_Register inInstruction)
- instr_valid_o  out  1  instr_o holds a real instruction (0 = bubble)

## Operation
- Registers:
  - fetch_pc_q: address of the current or next request; drives imem_addr_o.
  - target_q: pending redirect target.
  - skid_instr_q, skid_pc1_q: skid entry.
  - Output registers: pc_plus1_o, instr_o, instr_valid_o.
  - state.
- Reset values:
  - fetch_pc_q = RESET_PC; state = FETCH.
  - pc_plus1_o = 0; instr_o = NOP_INSTR (32'h0); instr_valid_o = 0.
  - imem_req_o = 0 while rst is high.
- States:
  - FETCH: imem_req_o = 1.
    - ack, no stall: outputs ← (rdata, fetch_pc_q+1, valid = 1); fetch_pc_q += 1.
    - ack, stall: skid ← (rdata, fetch_pc_q+1); fetch_pc_q += 1; go to HOLD.
    - no ack, no stall: outputs ← bubble (NOP_INSTR, valid = 0); pc_plus1_o unchanged.
    - no ack, stall: outputs hold.
  - HOLD: imem_req_o = 0; outputs hold. When stall_i = 0: outputs ← skid with valid = 1, go to FETCH.
  - DROP: imem_req_o = 1 at the old address until ack; response is discarded; outputs = bubble. On ack: fetch_pc_q ← target_q, go to FETCH.
- Redirect has priority over stall and over normal fetch:
  - Outputs become a bubble on the next edge, even if stall_i = 1.
  - FETCH with ack, or HOLD: fetch_pc_q ← redirect_pc_i; skid discarded; go to FETCH.
  - FETCH without ack: target_q ← redirect_pc_i; go to DROP.
  - DROP: target_q ← redirect_pc_i (newest target wins); stay in DROP.
- Handshake rule: imem_addr_o is stable while imem_req_o = 1 and ack has not been seen. A request is never withdrawn once issued.
- Arithmetic: all PC math is modulo 2^PC_W. 8'hFF + 1 = 8'h00, no flag.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. instr_o is valid one edge after the request cycle.
- N-cycle memory latency: N bubble cycles, then one valid cycle.
- Stall-to-freeze: zero cycles. Outputs hold on the edge where stall_i = 1.
- Skid release: data appears one edge after stall_i falls.
- Redirect to first target request: next cycle, or the cycle after the old ack when in DROP.
- Asynchronous reset mid-transaction forces the reset values immediately. The memory must drop any outstanding response on rst.

## Structure
- Shared package if_pkg holds:
  - PC_W, INSTR_W, NOP_INSTR;
  - fetch_state_t enum {FETCH, HOLD, DROP}.
- Sub-module if_skid_buf: one-entry register with load/clear/valid for (instr, pc+1).
- Next-state and PC logic stay in if_fetch_unit.

## Test plan
- Reset release, zero-wait memory returning addr×4: instr_o = 0, 4, 8 on consecutive cycles; pc_plus1_o = 1, 2, 3; valid stays high.
- stall_i high for 3 cycles with ack on the first: outputs frozen. After release, the skid instruction appears once and no instruction is lost or duplicated.
- Memory with 2-cycle latency: pattern valid, bubble, bubble, valid. imem_addr_o is constant while waiting.
- redirect_i to 8'h40 while a request to 8'h05 is outstanding: the response for 8'h05 is dropped. The next request is to 8'h40, and pc_plus1_o = 8'h41 when it returns.
- redirect_i together with stall_i: a bubble is emitted despite the stall; the skid is cleared.
- fetch_pc_q = 8'hFF: pc_plus1_o = 8'h00 and the next request goes to 8'h00.
